matrix_result_collector: RTL
============================

// Module: matrix_result_collector
// PURPOSE
//  Downstream stage of the sequential matrix multiplier. Accepts (z_out, z_i, z_j) over the z_stb/z_ack
//  handshake and stores each value at [z_i][z_j] in an MxM result buffer. Partial sums overwrite
//  earlier ones, so each element holds its final k=M-1 sum once the multiplier signals done.
//  After done, the block streams the full result row-major over a valid/ready port to the host.
// PARAMETERS
//  M      4   matrix dimension (MxM); M>=2
//  WIDTH  32  data width (IEEE-754 single from the multiplier's adder)
//  IDX_W  $clog2(M)  index width (derived, localparam)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous reset, active-high
//  start      in   1      arm collector; same pulse as sent to the multiplier
//  z_in       in   WIDTH  result value (multiplier z_out)
//  z_i        in   IDX_W  row index of z_in
//  z_j        in   IDX_W  column index of z_in
//  z_stb      in   1      z_in/z_i/z_j valid, held until acked
//  z_ack      out  1      registered single-cycle accept pulse
//  mul_done   in   1      multiplier done pulse (one cycle)
//  out_data   out  WIDTH  streamed element
//  out_valid  out  1      out_data valid
//  out_ready  in   1      sink ready
//  out_last   out  1      high with element [M-1][M-1]
//  busy       out  1      state != IDLE
//  missing    out  1      sticky: >=1 element never written this run
// BEHAVIOUR
//  Reset: state=IDLE; z_ack, out_valid, out_last, busy, missing = 0; out_data=0; written mask cleared.
//  Buffer contents are not reset; unwritten elements always read out as 0 (masked by written bit).
//  States: IDLE -> COLLECT -> DRAIN -> IDLE.
//  IDLE: z_ack held 0 (z_stb ignored). start=1 -> clear written mask and missing; go to COLLECT.
//  COLLECT: if z_stb && !z_ack: write mem[z_i][z_j]<=z_in, set written bit, z_ack=1 next cycle.
//   z_ack is never high two consecutive cycles; a held z_stb is accepted once per ack pulse.
//   Write-to-ack latency 1 cycle; back-to-back accepts possible every 2 cycles.
//   Indices >= M (non-power-of-2 M): ack but discard write.
//   mul_done: go to DRAIN next cycle; an accept in the same cycle still completes (write + ack).
//   start while in COLLECT: ignored.
//  DRAIN: ptr 0..M*M-1 row-major (ptr = i*M+j). On entry, missing <= ~&written.
//   out_valid=1; out_data = written[ptr] ? mem[ptr] : 0; out_last = (ptr==M*M-1).
//   Advance only on out_valid && out_ready; data/valid stable while stalled.
//   Handshake with out_last -> out_valid=0, go to IDLE. z_ack held 0; start ignored in DRAIN.
//  Reset mid-operation (any state): immediate return to reset values; no partial stream resumes.
//  rst has priority over start, z_stb, and mul_done in the same cycle.
// STRUCTURE
//  Package matrix_pkg: WIDTH default, idx_w(M) function, state enum (IDLE/COLLECT/DRAIN),
//   flat-address helper addr(i,j)=i*M+j; shared with the multiplier and operand loader.
//  One sub-module: matrix_result_ram (M*M x WIDTH, 1 write port, 1 async read port, no reset).
//  Written mask, ptr, handshake and FSM stay in this module.
// TESTING
//  1 Reset: assert rst 2 cycles mid-DRAIN -> all outputs 0, state IDLE, next run starts clean.
//  2 M=2 full run: write 1.0,2.0,3.0,4.0 to (0,0),(0,1),(1,0),(1,1) then mul_done ->
//    stream 3F800000,40000000,40400000,40800000; out_last on 4th; missing=0.
//  3 Overwrite: (0,0) gets 1.0 then 5.0 before mul_done -> first word streamed 40A00000.
//  4 Held z_stb 6 cycles -> z_ack pulses cycles 2,4,6 only; never consecutive.
//  5 Backpressure: out_ready toggles 1010... -> no word dropped or duplicated; data stable while stalled.
//  6 Skip (1,0) in M=2 -> third word 00000000, missing=1; z_stb in IDLE -> z_ack stays 0.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared types and helpers for the matrix multiplier datapath.
// Used by the operand loader, the multiplier and the result collector.
package matrix_pkg;

    localparam int DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN
    } state_t;

    function automatic int idx_w(input int m);
        return (m > 2) ? $clog2(m) : 1;
    endfunction

    function automatic int addr(input int m, input int i, input int j);
        return i * m + j;
    endfunction

endpackage

// File: rtl/matrix_result_ram.sv
// Result storage: one write port, one asynchronous read port.
// Contents are deliberately not reset; validity is tracked by the owner.
module matrix_result_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/matrix_result_collector.sv
// Collects multiplier results into an MxM buffer, then streams the
// finished matrix row-major to the host over valid/ready.
module matrix_result_collector
    import matrix_pkg::*;
#(
    parameter int M     = 4,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      z_in,
    input  logic [idx_w(M)-1:0]   z_i,
    input  logic [idx_w(M)-1:0]   z_j,
    input  logic                  z_stb,
    output logic                  z_ack,
    input  logic                  mul_done,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  missing
);

    localparam int IDX_W = idx_w(M);
    localparam int N     = M * M;
    localparam int PTR_W = (N > 2) ? $clog2(N) : 1;

    state_t             state;
    state_t             state_n;
    logic [N-1:0]       written;
    logic [N-1:0]       wmask;
    logic [N-1:0]       written_n;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   waddr;
    logic [WIDTH-1:0]   rdata;
    logic               idx_ok;
    logic               accept;
    logic               we;
    logic               fire;
    logic               last;

    assign idx_ok    = (int'(z_i) < M) && (int'(z_j) < M);
    assign accept    = (state == COLLECT) && z_stb && !z_ack;
    assign we        = accept && idx_ok;
    assign waddr     = PTR_W'(addr(M, int'(z_i), int'(z_j)));
    assign wmask     = we ? (N'(1) << waddr) : '0;
    assign written_n = written | wmask;

    assign last      = (ptr == PTR_W'(N - 1));
    assign out_valid = (state == DRAIN);
    assign fire      = out_valid && out_ready;
    assign out_last  = out_valid && last;
    assign out_data  = (out_valid && written[ptr]) ? rdata : '0;
    assign busy      = (state != IDLE);

    matrix_result_ram #(
        .DEPTH (N),
        .WIDTH (WIDTH),
        .AW    (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (z_in),
        .raddr (ptr),
        .rdata (rdata)
    );

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start) state_n = COLLECT;
            COLLECT: if (mul_done) state_n = DRAIN;
            DRAIN:   if (fire && last) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            z_ack   <= 1'b0;
            written <= '0;
            ptr     <= '0;
            missing <= 1'b0;
        end else begin
            state <= state_n;
            z_ack <= accept;
            if (state == IDLE && start) begin
                written <= '0;
                missing <= 1'b0;
                ptr     <= '0;
            end else begin
                written <= written_n;
            end
            // Include a write landing on the same edge as mul_done.
            if (state == COLLECT && state_n == DRAIN) begin
                missing <= ~&written_n;
            end
            if (fire) begin
                ptr <= last ? '0 : ptr + 1'b1;
            end
        end
    end

endmodule
